mult_result_writeback: RTL and testbench
========================================

Name: mult_result_writeback

Overview:
Downstream writeback sequencer for the 8-bit multiplier. On a start pulse it enables the multiplier's output for one cycle and captures the 16-bit product and flags. It then writes the product to the 8-bit register file in two beats, low byte first, and commits the flags to the status register. It sits between the multiplier's tri-state output bus and the register-file and status-register write ports.

Parameters:
ADDR_WIDTH, 3, width of the register-file destination address.
TIMEOUT_CYCLES, 16, stall limit used only when MULT_WB_TIMEOUT_EN is defined. Range 2..255.

Ports:
clock  input  1  system clock, rising edge.
nreset  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to write back the current product.
dest_low_addr  input  ADDR_WIDTH  destination register for product[7:0].
dest_high_addr  input  ADDR_WIDTH  destination register for product[15:8].
mult_in  input  16  product bus from the multiplier (mult_out).
flags_in  input  3  flag bus from the multiplier. [0]=zero, [1]=negative, [2] passed through.
mult_oe  output  1  drives the multiplier's oe input.
rf_wr_en  output  1  register-file write request.
rf_wr_addr  output  ADDR_WIDTH  register-file write address.
rf_wr_data  output  8  register-file write data.
rf_wr_ready  input  1  register file accepts the write this cycle.
status_wr_en  output  1  one-cycle status-register write strobe.
status_flags  output  3  flags to the status register.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when the sequence completes.
error  output  1  one-cycle pulse on timeout abort. Tied 0 without MULT_WB_TIMEOUT_EN.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low (nreset). Assertion forces state to IDLE and clears all outputs and holding registers to 0 immediately, including mid-sequence. No partial write completes after reset.
- States: IDLE, FETCH, WR_LO, WR_HI, FLAGS. Outputs are registered or decoded from state only; nothing is combinational from inputs except the handshake advance.
- IDLE:
  - All strobes are 0.
  - start=1 latches dest_low_addr and dest_high_addr, then moves to FETCH.
  - start is ignored in every other state; there is no queuing.
- FETCH (exactly 1 cycle):
  - mult_oe=1.
  - At the end of the cycle, mult_in is captured into prod_hold[15:0] and flags_in into flag_hold[2:0].
  - Next state is WR_LO.
  - mult_oe is 0 in all other states, so the bus is never driven outside FETCH.
- WR_LO:
  - rf_wr_en=1, rf_wr_addr=latched low address, rf_wr_data=prod_hold[7:0].
  - Holds until rf_wr_ready=1 is sampled, then moves to WR_HI. A ready-high in the first WR_LO cycle gives a 1-cycle beat.
- WR_HI:
  - Same as WR_LO with the high address and prod_hold[15:8].
  - On accept, moves to FLAGS.
- FLAGS (exactly 1 cycle):
  - status_wr_en=1, status_flags=flag_hold, done=1.
  - Next state is IDLE.
- Latency: with ready held high, start to done is 5 cycles (start sampled at edge 0, done high in cycle 4), and busy is high for 4 cycles.
- rf_wr_ready is a don't-care outside WR_LO and WR_HI.
- Equal low and high addresses: both writes are still issued in order, so the high byte is the final register value.
- Held product: prod_hold does not change after FETCH, even if mult_in changes.
- start in the same cycle as done: ignored, because the block is not yet in IDLE.

Optional Feature:
MULT_WB_TIMEOUT_EN.
- Defined:
  - An 8-bit stall counter resets on entry to WR_LO and WR_HI, and increments on each cycle with rf_wr_en=1 and rf_wr_ready=0.
  - When the counter reaches TIMEOUT_CYCLES-1 without an accept, the block aborts to IDLE and pulses error for 1 cycle.
  - On abort, status_wr_en and done are not pulsed. A write already accepted by the register file is not rolled back.
- Not defined: no counter is built, error is tied 0, and the block waits indefinitely for rf_wr_ready.

Test Plan:
- Product 0x1234, flags 3'b000, addrs lo=2 hi=3, ready tied 1 -> mult_oe high for 1 cycle. Writes are (2,0x34) then (3,0x12), followed by status_wr_en with 3'b000. done arrives 5 cycles after start.
- Product 0x8000, flags 3'b010, ready low for 3 cycles during WR_LO -> rf_wr_en holds (lo,0x00) for 4 cycles, then (hi,0x80). status_flags=3'b010.
- start pulsed again during WR_HI -> ignored, and exactly one done occurs. A new start after returning to IDLE runs a full second sequence.
- nreset asserted while in WR_LO -> all outputs are 0 immediately with no edge required. After release, state is IDLE and nothing is written until the next start.
- dest_low_addr=dest_high_addr=5, product 0xABCD -> writes (5,0xCD) then (5,0xAB).
- MULT_WB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ready stuck 0 -> error pulses after 16 stall cycles, state returns to IDLE, and neither status_wr_en nor done is asserted.

Source files
------------

// File: rtl/mult_result_writeback_if.sv
// Register-file and status-register write port bundle for mult_result_writeback.
interface mult_result_writeback_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  rf_wr_en;
    logic [ADDR_WIDTH-1:0] rf_wr_addr;
    logic [7:0]            rf_wr_data;
    logic                  rf_wr_ready;
    logic                  status_wr_en;
    logic [2:0]            status_flags;

    modport master (
        output rf_wr_en,
        output rf_wr_addr,
        output rf_wr_data,
        input  rf_wr_ready,
        output status_wr_en,
        output status_flags
    );

    modport slave (
        input  rf_wr_en,
        input  rf_wr_addr,
        input  rf_wr_data,
        output rf_wr_ready,
        input  status_wr_en,
        input  status_flags
    );
endinterface

// File: rtl/mult_result_writeback.sv
// Writeback sequencer: fetches the multiplier product, writes it to the register file in two
// byte beats (low first), then commits flags. Optional stall abort: define MULT_WB_TIMEOUT_EN.
module mult_result_writeback #(
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dest_low_addr,
    input  logic [ADDR_WIDTH-1:0] dest_high_addr,
    input  logic [15:0]           mult_in,
    input  logic [2:0]            flags_in,
    output logic                  mult_oe,
    mult_result_writeback_if.master wb,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] WR_LO = 3'd2;
    localparam logic [2:0] WR_HI = 3'd3;
    localparam logic [2:0] FLAGS = 3'd4;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] lo_addr_q, hi_addr_q;
    logic [15:0]           prod_hold_q;
    logic [2:0]            flag_hold_q;
    logic                  abort;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: state_d = WR_LO;
            WR_LO: begin
                if (abort)                state_d = IDLE;
                else if (wb.rf_wr_ready)  state_d = WR_HI;
            end
            WR_HI: begin
                if (abort)                state_d = IDLE;
                else if (wb.rf_wr_ready)  state_d = FLAGS;
            end
            FLAGS: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            lo_addr_q   <= '0;
            hi_addr_q   <= '0;
            prod_hold_q <= '0;
            flag_hold_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                lo_addr_q <= dest_low_addr;
                hi_addr_q <= dest_high_addr;
            end
            if (state_q == FETCH) begin
                prod_hold_q <= mult_in;
                flag_hold_q <= flags_in;
            end
        end
    end

    // All outputs decode from state so an asynchronous reset clears them without an edge.
    always_comb begin
        mult_oe         = (state_q == FETCH);
        busy            = (state_q != IDLE);
        done            = (state_q == FLAGS);
        wb.rf_wr_en     = (state_q == WR_LO) || (state_q == WR_HI);
        wb.rf_wr_addr   = '0;
        wb.rf_wr_data   = '0;
        wb.status_wr_en = (state_q == FLAGS);
        wb.status_flags = (state_q == FLAGS) ? flag_hold_q : 3'b000;
        if (state_q == WR_LO) begin
            wb.rf_wr_addr = lo_addr_q;
            wb.rf_wr_data = prod_hold_q[7:0];
        end else if (state_q == WR_HI) begin
            wb.rf_wr_addr = hi_addr_q;
            wb.rf_wr_data = prod_hold_q[15:8];
        end
    end

`ifdef MULT_WB_TIMEOUT_EN
    logic [7:0] stall_q;
    logic       error_q;
    logic       wr_entry;

    assign wr_entry = (state_d == WR_LO && state_q != WR_LO) ||
                      (state_d == WR_HI && state_q != WR_HI);
    assign abort    = wb.rf_wr_en && !wb.rf_wr_ready &&
                      (stall_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            stall_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= abort;
            if (wr_entry)                            stall_q <= '0;
            else if (wb.rf_wr_en && !wb.rf_wr_ready) stall_q <= stall_q + 8'd1;
        end
    end

    assign error = error_q;
`else
    assign abort = 1'b0;
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mult_result_writeback.sv
// Directed self-checking bench for mult_result_writeback.
module tb_mult_result_writeback;

    logic        clock = 1'b0;
    logic        nreset;
    logic        start;
    logic [2:0]  dest_low_addr;
    logic [2:0]  dest_high_addr;
    logic [15:0] mult_in;
    logic [2:0]  flags_in;
    logic        mult_oe;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    mult_result_writeback_if #(.ADDR_WIDTH(3)) wb_if ();

    mult_result_writeback #(
        .ADDR_WIDTH     (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock          (clock),
        .nreset         (nreset),
        .start          (start),
        .dest_low_addr  (dest_low_addr),
        .dest_high_addr (dest_high_addr),
        .mult_in        (mult_in),
        .flags_in       (flags_in),
        .mult_oe        (mult_oe),
        .wb             (wb_if),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        start = 1'b0;
        dest_low_addr = 3'd0;
        dest_high_addr = 3'd0;
        mult_in = 16'h0;
        flags_in = 3'b0;
        wb_if.rf_wr_ready = 1'b0;
        step();
        step();
        checks++;
        if ({mult_oe, busy, done, error, wb_if.rf_wr_en, wb_if.status_wr_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: oe,busy,done,err,wr,st=%b expected 000000",
                     {mult_oe, busy, done, error, wb_if.rf_wr_en, wb_if.status_wr_en});
        end
        checks++;
        if ({wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.status_flags} !== 14'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h data=%h flags=%b expected 0 00 000",
                     wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.status_flags);
        end
        nreset = 1'b1;
        step();
    endtask

    // Full sequence with ready held high; bus inputs are disturbed after sampling.
    task automatic test_sequence(input string name, input logic [2:0] lo, input logic [2:0] hi,
                                 input logic [15:0] prod, input logic [2:0] flg);
        logic [15:0] p;
        p = prod;
        wb_if.rf_wr_ready = 1'b1;
        dest_low_addr = lo;
        dest_high_addr = hi;
        mult_in = p;
        flags_in = flg;
        start = 1'b1;
        step();
        start = 1'b0;
        dest_low_addr = ~lo;
        dest_high_addr = ~hi;
        checks++;
        if (mult_oe !== 1'b1 || busy !== 1'b1 || wb_if.rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s fetch: oe=%b busy=%b wr=%b expected 1 1 0",
                     name, mult_oe, busy, wb_if.rf_wr_en);
        end
        step();
        mult_in = ~p;
        flags_in = ~flg;
        checks++;
        if (wb_if.rf_wr_en !== 1'b1 || wb_if.rf_wr_addr !== lo ||
            wb_if.rf_wr_data !== p[7:0] || mult_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s wr_lo: en=%b addr=%0d data=%h oe=%b expected 1 %0d %h 0",
                     name, wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, mult_oe, lo, p[7:0]);
        end
        step();
        checks++;
        if (wb_if.rf_wr_en !== 1'b1 || wb_if.rf_wr_addr !== hi ||
            wb_if.rf_wr_data !== p[15:8] || done !== 1'b0) begin
            errors++;
            $display("FAIL %s wr_hi: en=%b addr=%0d data=%h done=%b expected 1 %0d %h 0",
                     name, wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, done, hi, p[15:8]);
        end
        step();
        checks++;
        if (wb_if.status_wr_en !== 1'b1 || wb_if.status_flags !== flg || done !== 1'b1 ||
            busy !== 1'b1 || wb_if.rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s flags: st=%b flags=%b done=%b busy=%b wr=%b expected 1 %b 1 1 0",
                     name, wb_if.status_wr_en, wb_if.status_flags, done, busy, wb_if.rf_wr_en, flg);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wb_if.status_wr_en !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b st=%b err=%b expected 0 0 0 0",
                     name, busy, done, wb_if.status_wr_en, error);
        end
    endtask

    task automatic test_stall();
        wb_if.rf_wr_ready = 1'b0;
        dest_low_addr = 3'd1;
        dest_high_addr = 3'd6;
        mult_in = 16'h8000;
        flags_in = 3'b010;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wb_if.rf_wr_en !== 1'b1 || wb_if.rf_wr_addr !== 3'd1 ||
                wb_if.rf_wr_data !== 8'h00) begin
                errors++;
                $display("FAIL stall_lo[%0d]: en=%b addr=%0d data=%h expected 1 1 00",
                         i, wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data);
            end
            if (i == 3) wb_if.rf_wr_ready = 1'b1;
            step();
        end
        checks++;
        if (wb_if.rf_wr_en !== 1'b1 || wb_if.rf_wr_addr !== 3'd6 || wb_if.rf_wr_data !== 8'h80) begin
            errors++;
            $display("FAIL stall_hi: en=%b addr=%0d data=%h expected 1 6 80",
                     wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data);
        end
        step();
        checks++;
        if (wb_if.status_wr_en !== 1'b1 || wb_if.status_flags !== 3'b010 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_flags: st=%b flags=%b done=%b expected 1 010 1",
                     wb_if.status_wr_en, wb_if.status_flags, done);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int dones;
        dones = 0;
        wb_if.rf_wr_ready = 1'b1;
        dest_low_addr = 3'd4;
        dest_high_addr = 3'd0;
        mult_in = 16'h5A3C;
        flags_in = 3'b100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        // Now in WR_HI; hold start through FLAGS as well.
        dest_low_addr = 3'd7;
        dest_high_addr = 3'd7;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) dones++;
            step();
            if (i == 1) start = 1'b0;
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL start_ignored_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (busy !== 1'b0 || wb_if.rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle: busy=%b wr=%b expected 0 0", busy, wb_if.rf_wr_en);
        end
        test_sequence("second_run", 3'd7, 3'd1, 16'hC3E1, 3'b011);
    endtask

    task automatic test_reset_mid();
        wb_if.rf_wr_ready = 1'b0;
        dest_low_addr = 3'd3;
        dest_high_addr = 3'd4;
        mult_in = 16'hFFFF;
        flags_in = 3'b111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (wb_if.rf_wr_en !== 1'b1 || wb_if.rf_wr_data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_pre: en=%b data=%h expected 1 ff",
                     wb_if.rf_wr_en, wb_if.rf_wr_data);
        end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if ({mult_oe, busy, done, wb_if.rf_wr_en, wb_if.status_wr_en} !== 5'b0 ||
            wb_if.rf_wr_addr !== 3'd0 || wb_if.rf_wr_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: oe,busy,done,wr,st=%b addr=%0d data=%h expected 0 0 00",
                     {mult_oe, busy, done, wb_if.rf_wr_en, wb_if.status_wr_en},
                     wb_if.rf_wr_addr, wb_if.rf_wr_data);
        end
        step();
        nreset = 1'b1;
        wb_if.rf_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || wb_if.rf_wr_en !== 1'b0 || wb_if.status_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: busy=%b wr=%b st=%b expected 0 0 0",
                         i, busy, wb_if.rf_wr_en, wb_if.status_wr_en);
            end
        end
    endtask

`ifdef MULT_WB_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        seen = 0;
        wb_if.rf_wr_ready = 1'b0;
        dest_low_addr = 3'd2;
        dest_high_addr = 3'd3;
        mult_in = 16'h1111;
        flags_in = 3'b001;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            if (error === 1'b1 || wb_if.rf_wr_en !== 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL timeout_early: %0d bad cycles, expected 0", seen);
        end
        step();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wb_if.status_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: err=%b busy=%b done=%b st=%b expected 1 0 0 0",
                     error, busy, done, wb_if.status_wr_en);
        end
        step();
        checks++;
        if (error !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: err=%b done=%b expected 0 0", error, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence("basic", 3'd2, 3'd3, 16'h1234, 3'b000);
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_sequence("equal_addr", 3'd5, 3'd5, 16'hABCD, 3'b101);
`ifdef MULT_WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
